dual_stack_arbiter: RTL
=======================

Name: dual_stack_arbiter

Overview:
- Shares one dual_stack instance between two independent requesters (R0, R1).
- Accepts PEEK/PUSH/POP commands over valid/ready handshakes and arbitrates between the two requesters.
- Sequences the stack's one-cycle push/pop strobes, checks full/empty before every strobe and returns one response per accepted command.
- Sits between the stack datapath and the host-side command decoders.

Parameters:
- DATA_W, 8: width of command data, stack data and response data.
- FAIR, 1: 1 = round-robin arbitration; 0 = fixed priority, R0 wins.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- r0_valid  in  1  R0 command valid
- r0_ready  out  1  R0 command accepted this cycle
- r0_op  in  2  00 PEEK, 01 PUSH, 10 POP, 11 MOVE/reserved
- r0_sel  in  1  target stack: 0 = stack1, 1 = stack2
- r0_data  in  DATA_W  push data
- r0_rsp_valid  out  1  one-cycle response strobe
- r0_rsp_data  out  DATA_W  peeked/popped byte, else 0
- r0_rsp_err  out  1  command rejected
- r1_valid, r1_ready, r1_op, r1_sel, r1_data, r1_rsp_valid, r1_rsp_data, r1_rsp_err: same as R0, for R1
- stk_select  out  1  to stack stack_select
- stk_push  out  1  to stack push
- stk_pop  out  1  to stack pop
- stk_data_in  out  DATA_W  to stack data_in
- stk_data_out  in  DATA_W  stack data_out; contract: top of the selected stack, combinational, 0 if empty
- s1_empty, s1_full, s2_empty, s2_full  in  1 each  stack status flags
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset, asynchronous: state = IDLE, last_grant = R1 (so R0 wins first), all outputs 0, latched command discarded, no response issued.
- Handshake:
  - A command transfers when rN_valid && rN_ready.
  - rN_ready is combinational and is high only in IDLE, for the granted requester.
  - The requester holds valid/op/sel/data stable until ready.
- Arbitration, IDLE only:
  - With one valid, that requester is granted.
  - With both valid and FAIR = 1, grant the requester other than last_grant; with FAIR = 0, grant R0.
  - On grant, latch op/sel/data/id, update last_grant and go to EXEC.
- EXEC, one cycle:
  - stk_select = sel; check flags of the selected stack.
  - PUSH: if full, set err and assert no strobe; else stk_push = 1 and stk_data_in = data.
  - POP: if empty, set err; else stk_pop = 1 and capture stk_data_out into the response register in the same cycle.
  - PEEK: if empty, set err; else capture stk_data_out, no strobe.
  - op 11: behaviour per Optional Feature.
  - Next state: RESP.
- RESP, one cycle:
  - Granted requester's rsp_valid = 1, rsp_data = captured byte, or 0 for PUSH and for any error; rsp_err = err.
  - The other requester's rsp outputs stay 0. Next state: IDLE.
- Latency: accept at cycle N, stack strobe at N+1, rsp_valid at N+2. Throughput is one command per 3 cycles (4 for MOVE).
- Stack strobes: at most one strobe per cycle, never both push and pop, never asserted outside EXEC/EXEC2. stk_data_in = 0 when stk_push = 0.
- Reset mid-operation: strobes drop immediately and the in-flight command is lost with no response.

Optional Feature:
- Macro: DUAL_STACK_ARBITER_MOVE_EN.
- Defined, op 11 = MOVE, which transfers the top of stack sel to stack ~sel:
  - EXEC: error if src is empty or dst is full. Both flags are checked before any strobe, so an error changes neither stack.
  - Otherwise stk_pop on src, capturing stk_data_out.
  - EXEC2: stk_select = ~sel, stk_push = 1 with the captured byte.
  - RESP: rsp_data = moved byte.
- Undefined: op 11 is answered at N+2 with rsp_err = 1, rsp_data = 0, no stack strobe; EXEC2 does not exist.

Test Plan:
- R0 PUSH sel0 0xA5, then R0 POP sel0 -> first rsp: err 0, data 0x00 at N+2; second rsp: data 0xA5, err 0; exactly one stk_push and one stk_pop pulse.
- R1 POP sel1 on empty stack2 -> r1_rsp_err = 1, rsp_data 0x00, stk_pop never asserted.
- 16 R0 PUSHes to sel0 then a 17th PUSH 0x11 -> 17th rsp_err = 1, no stk_push for it; PEEK sel0 returns the 16th byte.
- Both valid continuously, FAIR = 1 -> grants alternate R0, R1, R0, R1; with FAIR = 0 all grants go to R0 while r0_valid is high.
- rst pulse during EXEC of a PUSH -> stk_push falls asynchronously, no rsp_valid, busy = 0, next grant goes to R0.
- With MOVE_EN: push 0x3C to sel0, MOVE sel0 -> rsp data 0x3C; PEEK sel1 = 0x3C; PEEK sel0 errs. Without MOVE_EN: op 11 -> rsp_err = 1.

Source files
------------

// File: rtl/dual_stack_arbiter_if.sv
// Command/response and stack-side signal bundle for dual_stack_arbiter.
// slave  : the arbiter's view (takes commands, drives stack strobes)
// master : the environment's view (requesters plus the dual stack)
interface dual_stack_arbiter_if #(
   parameter int DATA_W = 8
);
   logic              r0_valid;
   logic              r0_ready;
   logic [1:0]        r0_op;
   logic              r0_sel;
   logic [DATA_W-1:0] r0_data;
   logic              r0_rsp_valid;
   logic [DATA_W-1:0] r0_rsp_data;
   logic              r0_rsp_err;

   logic              r1_valid;
   logic              r1_ready;
   logic [1:0]        r1_op;
   logic              r1_sel;
   logic [DATA_W-1:0] r1_data;
   logic              r1_rsp_valid;
   logic [DATA_W-1:0] r1_rsp_data;
   logic              r1_rsp_err;

   logic              stk_select;
   logic              stk_push;
   logic              stk_pop;
   logic [DATA_W-1:0] stk_data_in;
   logic [DATA_W-1:0] stk_data_out;
   logic              s1_empty;
   logic              s1_full;
   logic              s2_empty;
   logic              s2_full;

   logic              busy;

   modport slave (
      input  r0_valid, r0_op, r0_sel, r0_data,
      output r0_ready, r0_rsp_valid, r0_rsp_data, r0_rsp_err,
      input  r1_valid, r1_op, r1_sel, r1_data,
      output r1_ready, r1_rsp_valid, r1_rsp_data, r1_rsp_err,
      output stk_select, stk_push, stk_pop, stk_data_in,
      input  stk_data_out, s1_empty, s1_full, s2_empty, s2_full,
      output busy
   );

   modport master (
      output r0_valid, r0_op, r0_sel, r0_data,
      input  r0_ready, r0_rsp_valid, r0_rsp_data, r0_rsp_err,
      output r1_valid, r1_op, r1_sel, r1_data,
      input  r1_ready, r1_rsp_valid, r1_rsp_data, r1_rsp_err,
      input  stk_select, stk_push, stk_pop, stk_data_in,
      output stk_data_out, s1_empty, s1_full, s2_empty, s2_full,
      input  busy
   );
endinterface

// File: rtl/dual_stack_arbiter.sv
// Two-requester arbiter in front of a shared dual stack.
// Optional MOVE command (op 11) enabled by defining DUAL_STACK_ARBITER_MOVE_EN;
// without it op 11 is rejected with an error response.
//
// state  | meaning
// IDLE   | waiting for a command, grant issued combinationally
// EXEC   | flags checked, push/pop strobe (pop side of MOVE), data captured
// EXEC2  | push side of MOVE onto the other stack (MOVE build only)
// RESP   | one-cycle response to the granted requester
module dual_stack_arbiter #(
   parameter int DATA_W = 8,
   parameter int FAIR   = 1
) (
   input logic                clk,
   input logic                rst,
   dual_stack_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_EXEC  = 2'd1,
      ST_RESP  = 2'd2
`ifdef DUAL_STACK_ARBITER_MOVE_EN
      ,ST_EXEC2 = 2'd3
`endif
   } state_t;

   localparam logic [1:0] OP_PEEK = 2'b00;
   localparam logic [1:0] OP_PUSH = 2'b01;
   localparam logic [1:0] OP_POP  = 2'b10;

   state_t            r_state;
   state_t            w_next;
   logic              r_last_grant;
   logic [1:0]        r_op;
   logic              r_sel;
   logic [DATA_W-1:0] r_data;
   logic              r_id;
   logic              r_err;
   logic [DATA_W-1:0] r_rsp_data;

   logic              w_gnt_valid;
   logic              w_gnt_id;
   logic              w_accept;
   logic              w_err;
   logic              w_cap;
   logic              w_src_empty;
   logic              w_src_full;
`ifdef DUAL_STACK_ARBITER_MOVE_EN
   logic              w_dst_full;
`endif

   // Grant selection: sole requester wins, ties go round-robin or to R0.
   always_comb begin
      w_gnt_valid = bus.r0_valid | bus.r1_valid;
      if (bus.r0_valid && bus.r1_valid)
         w_gnt_id = (FAIR != 0) ? ~r_last_grant : 1'b0;
      else
         w_gnt_id = bus.r1_valid;
      w_accept = (r_state == ST_IDLE) && w_gnt_valid && !rst;
   end

   // Status flags of the stack named by the latched command.
   always_comb begin
      w_src_empty = r_sel ? bus.s2_empty : bus.s1_empty;
      w_src_full  = r_sel ? bus.s2_full  : bus.s1_full;
`ifdef DUAL_STACK_ARBITER_MOVE_EN
      w_dst_full  = r_sel ? bus.s1_full  : bus.s2_full;
`endif
   end

   // Next state, handshake, stack strobes and response outputs.
   always_comb begin
      w_next           = r_state;
      w_err            = 1'b0;
      w_cap            = 1'b0;
      bus.r0_ready     = w_accept && !w_gnt_id;
      bus.r1_ready     = w_accept &&  w_gnt_id;
      bus.stk_select   = 1'b0;
      bus.stk_push     = 1'b0;
      bus.stk_pop      = 1'b0;
      bus.stk_data_in  = '0;
      bus.r0_rsp_valid = 1'b0;
      bus.r0_rsp_data  = '0;
      bus.r0_rsp_err   = 1'b0;
      bus.r1_rsp_valid = 1'b0;
      bus.r1_rsp_data  = '0;
      bus.r1_rsp_err   = 1'b0;
      bus.busy         = (r_state != ST_IDLE);
      case (r_state)
         ST_IDLE: begin
            if (w_accept) w_next = ST_EXEC;
         end
         ST_EXEC: begin
            bus.stk_select = r_sel;
            w_next         = ST_RESP;
            case (r_op)
               OP_PEEK: begin
                  w_err = w_src_empty;
                  w_cap = !w_src_empty;
               end
               OP_PUSH: begin
                  w_err           = w_src_full;
                  bus.stk_push    = !w_src_full;
                  bus.stk_data_in = w_src_full ? '0 : r_data;
               end
               OP_POP: begin
                  w_err       = w_src_empty;
                  w_cap       = !w_src_empty;
                  bus.stk_pop = !w_src_empty;
               end
               default: begin
`ifdef DUAL_STACK_ARBITER_MOVE_EN
                  // Both ends are checked up front so a failed move touches neither stack.
                  w_err       = w_src_empty | w_dst_full;
                  w_cap       = !w_err;
                  bus.stk_pop = !w_err;
                  if (!w_err) w_next = ST_EXEC2;
`else
                  w_err = 1'b1;
`endif
               end
            endcase
         end
`ifdef DUAL_STACK_ARBITER_MOVE_EN
         ST_EXEC2: begin
            bus.stk_select  = ~r_sel;
            bus.stk_push    = 1'b1;
            bus.stk_data_in = r_rsp_data;
            w_next          = ST_RESP;
         end
`endif
         ST_RESP: begin
            if (r_id) begin
               bus.r1_rsp_valid = 1'b1;
               bus.r1_rsp_data  = r_rsp_data;
               bus.r1_rsp_err   = r_err;
            end else begin
               bus.r0_rsp_valid = 1'b1;
               bus.r0_rsp_data  = r_rsp_data;
               bus.r0_rsp_err   = r_err;
            end
            w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // State register, command latch and response capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_last_grant <= 1'b1;
         r_op         <= 2'b00;
         r_sel        <= 1'b0;
         r_data       <= '0;
         r_id         <= 1'b0;
         r_err        <= 1'b0;
         r_rsp_data   <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_last_grant <= w_gnt_id;
            r_id         <= w_gnt_id;
            r_op         <= w_gnt_id ? bus.r1_op   : bus.r0_op;
            r_sel        <= w_gnt_id ? bus.r1_sel  : bus.r0_sel;
            r_data       <= w_gnt_id ? bus.r1_data : bus.r0_data;
         end
         if (r_state == ST_EXEC) begin
            r_err      <= w_err;
            r_rsp_data <= w_cap ? bus.stk_data_out : '0;
         end
      end
   end

endmodule
